// File: rtl/fifo_byte_serializer_pkg.sv
// ============================================================================
// fifo_pkg : shared types and constants for the FIFO byte serializer
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int BYTE_WIDTH     = 8;
  localparam int BYTES_PER_WORD = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_WIDTH      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_byte_serializer_if.sv
// ============================================================================
// fifo_byte_serializer_if : FIFO read port plus valid/ready byte stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface fifo_byte_serializer_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int BYTE_WIDTH = fifo_pkg::BYTE_WIDTH
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_re;
  logic [BYTE_WIDTH-1:0] byte_out;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  byte_last;

  // master = the serializer, slave = FIFO plus byte sink
  modport master (
    input  fifo_empty, fifo_data, byte_ready,
    output fifo_re, byte_out, byte_valid, byte_last
  );

  modport slave (
    output fifo_empty, fifo_data, byte_ready,
    input  fifo_re, byte_out, byte_valid, byte_last
  );

endinterface

`default_nettype wire

// File: rtl/fifo_byte_serializer_byte_select.sv
// ============================================================================
// fifo_byte_serializer_byte_select : combinational N:1 byte mux
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_byte_serializer_byte_select
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int BYTE_WIDTH = fifo_pkg::BYTE_WIDTH,
  parameter int MSB_FIRST  = 0,
  parameter int IW         = fifo_pkg::IDX_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [IW-1:0]         idx_i,
  output logic [BYTE_WIDTH-1:0] byte_o
);

  localparam int N = DATA_WIDTH / BYTE_WIDTH;

  logic [BYTE_WIDTH-1:0] w_bytes [N];

  // w_bytes[i] is the i-th byte in transmit order
  for (genvar g = 0; g < N; g++) begin : g_split
    if (MSB_FIRST != 0) begin : g_msb
      assign w_bytes[g] = word_i[(N-1-g)*BYTE_WIDTH +: BYTE_WIDTH];
    end else begin : g_lsb
      assign w_bytes[g] = word_i[g*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign byte_o = w_bytes[idx_i];

endmodule

`default_nettype wire

// File: rtl/fifo_byte_serializer.sv
// ============================================================================
// fifo_byte_serializer : pops FIFO words and streams them out byte by byte
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_byte_serializer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int BYTE_WIDTH = fifo_pkg::BYTE_WIDTH,
  parameter int MSB_FIRST  = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  fifo_byte_serializer_if.master       ser,
  output logic                         busy_o,
  output logic [CNT_WIDTH-1:0]         word_count_o
);

  localparam int N  = DATA_WIDTH / BYTE_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         idx_q,   idx_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
  logic [BYTE_WIDTH-1:0] sel_byte;
  logic                  send_st;
  logic                  can_pop;

  assign send_st = (state_q == SEND);
  assign can_pop = en_i && !ser.fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (can_pop) state_d = POP;
      POP:  state_d = LOAD;
      LOAD: begin
        shift_d = ser.fifo_data;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (ser.byte_ready) begin
          if (idx_q == LAST_IDX) begin
            // word fully accepted: chain straight into the next pop if allowed
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            state_d = can_pop ? POP : IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fifo_byte_serializer_byte_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .MSB_FIRST  (MSB_FIRST),
    .IW         (IW)
  ) u_byte_select (
    .word_i (shift_q),
    .idx_i  (idx_q),
    .byte_o (sel_byte)
  );

  assign ser.fifo_re    = (state_q == POP);
  assign ser.byte_valid = send_st;
  assign ser.byte_out   = send_st ? sel_byte : '0;
  assign ser.byte_last  = send_st && (idx_q == LAST_IDX);
  assign busy_o         = (state_q != IDLE);
  assign word_count_o   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_byte_serializer.sv
// ============================================================================
// tb_fifo_byte_serializer : LSB-first and MSB-first instances driven in lockstep
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_byte_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic rdy = 1'b1;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by the sequence

  always #5 clk = ~clk;

  fifo_byte_serializer_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) bus0 ();
  fifo_byte_serializer_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) bus1 ();

  logic        busy0, busy1;
  logic [15:0] wc0, wc1;

  fifo_byte_serializer #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(16)) u_dut0 (
    .clk(clk), .rst(rst), .en_i(en), .ser(bus0), .busy_o(busy0), .word_count_o(wc0)
  );
  fifo_byte_serializer #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .en_i(en), .ser(bus1), .busy_o(busy1), .word_count_o(wc1)
  );

  logic [31:0] d_data [2];
  logic        d_empty [2] = '{1'b1, 1'b1};
  assign bus0.fifo_data  = d_data[0];
  assign bus1.fifo_data  = d_data[1];
  assign bus0.fifo_empty = d_empty[0];
  assign bus1.fifo_empty = d_empty[1];
  assign bus0.byte_ready = rdy;
  assign bus1.byte_ready = rdy;

  logic [1:0] w_valid, w_last, w_re, w_busy;
  logic [7:0]  w_byte [2];
  logic [15:0] w_wc   [2];
  assign w_valid = {bus1.byte_valid, bus0.byte_valid};
  assign w_last  = {bus1.byte_last,  bus0.byte_last};
  assign w_re    = {bus1.fifo_re,    bus0.fifo_re};
  assign w_busy  = {busy1, busy0};
  assign w_byte[0] = bus0.byte_out;
  assign w_byte[1] = bus1.byte_out;
  assign w_wc[0]   = wc0;
  assign w_wc[1]   = wc1;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] fq    [2][$];
  logic [8:0]  exp_q [2][$];   // {last, byte}
  int          hs  [2] = '{0, 0};
  int          mwc [2] = '{0, 0};
  int          rc  [2] = '{0, 0};
  bit          held [2] = '{0, 0};
  logic [7:0]  hb [2];
  logic        hl [2];
  logic [31:0] pend [2];
  bit          pend_v [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // FIFO model: read strobe seen in cycle t, data presented during cycle t+1 only
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      d_data[k] = pend_v[k] ? pend[k] : $urandom;
      pend_v[k] = 1'b0;
      if (w_re[k]) begin
        chk(fq[k].size() != 0, $sformatf("underread[%0d]", k), fq[k].size(), 1);
        if (fq[k].size() != 0) begin
          pend[k]   = fq[k].pop_front();
          pend_v[k] = 1'b1;
        end
        rc[k]++;
      end
      d_empty[k] = (fq[k].size() == 0);
    end
  end

  always @(negedge clk) begin
    if (rdy_mode == 1)      rdy = 1'($urandom_range(0, 1));
    else if (rdy_mode == 0) rdy = 1'b1;
  end

  task automatic mon_step(input int k);
    logic [8:0] e;
    if (!rst) begin
      mwc[k]  = 0;
      held[k] = 1'b0;
      return;
    end
    if (!w_valid[k])
      chk(w_byte[k] == 8'h00 && !w_last[k], $sformatf("idle_out_zero[%0d]", k), {w_last[k], w_byte[k]}, 0);
    if (held[k])
      chk(w_valid[k] && w_byte[k] == hb[k] && w_last[k] == hl[k], $sformatf("backpressure_hold[%0d]", k),
          {w_valid[k], w_last[k], w_byte[k]}, {1'b1, hl[k], hb[k]});
    chk(w_wc[k] == 16'(mwc[k]), $sformatf("word_count[%0d]", k), w_wc[k], 16'(mwc[k]));
    if (w_valid[k] && rdy) begin
      chk(exp_q[k].size() != 0, $sformatf("unexpected_byte[%0d]", k), {w_last[k], w_byte[k]}, 0);
      if (exp_q[k].size() != 0) begin
        e = exp_q[k].pop_front();
        chk({w_last[k], w_byte[k]} == e, $sformatf("byte_stream[%0d]", k), {w_last[k], w_byte[k]}, e);
      end
      hs[k]++;
      if (w_last[k]) mwc[k] = (mwc[k] + 1) & 32'hFFFF;
    end
    held[k] = w_valid[k] && !rdy;
    hb[k]   = w_byte[k];
    hl[k]   = w_last[k];
  endtask

  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) mon_step(k);
  end

  // Reference byte orders from plain shifts of the pushed word
  task automatic add_exp(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      exp_q[0].push_back({1'(i == 3), 8'((w >> (8 * i)) & 32'hFF)});
      exp_q[1].push_back({1'(i == 3), 8'((w >> (8 * (3 - i))) & 32'hFF)});
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit expect_out);
    fq[0].push_back(w);
    fq[1].push_back(w);
    if (expect_out) add_exp(w);
  endtask

  task automatic wait_drain(input int budget, input string nm, output int cycles);
    bit done = 1'b0;
    int c0 = cyc;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && w_busy == 2'b00) done = 1'b1;
    end
    cycles = cyc - c0;
    chk(done, {nm, "_drain"}, exp_q[0].size(), 0);
  endtask

  task automatic wait_hs(input int target, input string nm);
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (hs[0] >= target) done = 1'b1;
    end
    chk(done, {nm, "_hs_wait"}, hs[0], target);
  endtask

  initial begin
    int r0, w0, n;
    for (int k = 0; k < 2; k++) d_data[k] = '0;

    // reset state
    repeat (3) @(negedge clk);
    #3;
    for (int k = 0; k < 2; k++)
      chk(!w_re[k] && !w_valid[k] && !w_last[k] && !w_busy[k] && w_byte[k] == 0 && w_wc[k] == 0,
          $sformatf("reset_state[%0d]", k), {w_re[k], w_valid[k], w_last[k], w_busy[k], w_byte[k]}, 0);
    @(negedge clk) rst = 1'b1;

    // single word: 3-cycle latency then 4 bytes back to back
    r0 = rc[0];
    push_word(32'h04030201, 1'b1);
    en = 1'b1;
    wait_drain(50, "t1", n);
    chk(n == 7, "t1_cycles", n, 7);
    chk(rc[0] - r0 == 1, "t1_re_pulses", rc[0] - r0, 1);
    chk(wc0 == 16'd1 && wc1 == 16'd1, "t1_word_count", {wc1, wc0}, 32'h0001_0001);

    // backpressure on the second byte
    w0 = mwc[0];
    push_word(32'h04030201, 1'b1);
    wait_hs(hs[0] + 1, "t3");
    rdy_mode = 2;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #3;
      chk(bus0.byte_valid && bus0.byte_out == 8'h02, "t3_hold_lsb", {bus0.byte_valid, bus0.byte_out}, 9'h102);
      chk(bus1.byte_valid && bus1.byte_out == 8'h03, "t3_hold_msb", {bus1.byte_valid, bus1.byte_out}, 9'h103);
    end
    @(negedge clk) rdy = 1'b1;
    rdy_mode = 0;
    wait_drain(50, "t3", n);
    chk(mwc[0] - w0 == 1 && wc0 == 16'(mwc[0]), "t3_word_count", wc0, 16'(w0 + 1));

    // back-to-back words: N bytes every N+2 cycles
    en = 1'b0;
    r0 = rc[0];
    w0 = wc0;
    for (int i = 0; i < 5; i++) push_word(32'(i), 1'b1);
    @(negedge clk) en = 1'b1;
    wait_drain(100, "t4", n);
    chk(n == 31, "t4_cycles", n, 31);
    chk(rc[0] - r0 == 5, "t4_re_pulses", rc[0] - r0, 5);
    chk(int'(wc0) - w0 == 5, "t4_word_count", wc0, w0 + 5);

    // empty FIFO with en high: no pop, never busy
    r0 = rc[0];
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #3;
      chk(w_re == 2'b00 && w_busy == 2'b00, "t5_empty_idle", {w_re, w_busy}, 0);
    end
    chk(rc[0] == r0, "t5_empty_no_pop", rc[0] - r0, 0);

    // drop en mid-word: word completes, queued word stays in FIFO
    en = 1'b0;
    push_word(32'hAABBCCDD, 1'b1);
    push_word(32'h11223344, 1'b0);
    r0 = rc[0];
    @(negedge clk) en = 1'b1;
    wait_hs(hs[0] + 2, "t5b");
    en = 1'b0;
    wait_drain(50, "t5b", n);
    repeat (10) @(negedge clk);
    chk(rc[0] - r0 == 1, "t5b_re_pulses", rc[0] - r0, 1);
    chk(fq[0].size() == 1 && w_busy == 2'b00, "t5b_word_left", fq[0].size(), 1);

    // reset after the first byte: partial word dropped, next word from byte 0
    add_exp(32'h11223344);
    push_word(32'h55667788, 1'b1);
    r0 = rc[0];
    en = 1'b1;
    wait_hs(hs[0] + 1, "t6");
    rst = 1'b0;
    for (int k = 0; k < 2; k++) repeat (3) void'(exp_q[k].pop_front());
    @(negedge clk);
    #3;
    for (int k = 0; k < 2; k++)
      chk(!w_valid[k] && !w_busy[k] && w_wc[k] == 0, $sformatf("t6_reset_mid_send[%0d]", k),
          {w_valid[k], w_busy[k], w_wc[k]}, 0);
    @(negedge clk) rst = 1'b1;
    wait_drain(100, "t6", n);
    chk(rc[0] - r0 == 2, "t6_re_pulses", rc[0] - r0, 2);
    chk(wc0 == 16'd1 && wc1 == 16'd1, "t6_word_count", {wc1, wc0}, 32'h0001_0001);

    // random words, random gaps, random backpressure
    rdy_mode = 1;
    r0 = rc[0];
    for (int i = 0; i < 24; i++) begin
      push_word($urandom, 1'b1);
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    wait_drain(3000, "t7", n);
    chk(rc[0] - r0 == 24 && fq[0].size() == 0 && fq[1].size() == 0, "t7_all_popped", rc[0] - r0, 24);
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/fifo_byte_serializer.md
Name: fifo_byte_serializer

Overview:
Downstream drain stage for the 32-bit FIFO buffer. It pops words from the FIFO read side using re/Empty/data_out, splits each word into bytes, and presents the bytes on a valid/ready byte stream for a byte-wide link such as a UART TX or SPI shifter. It is the only consumer of the FIFO read port.

Parameters:
DATA_WIDTH, 32, FIFO word width; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, output symbol width
MSB_FIRST, 0, 0 = least-significant byte sent first; 1 = most-significant byte first
CNT_WIDTH, 16, width of the completed-word counter

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous reset, active-low (0 = reset, sampled on the clk rising edge)
en  input  1  permits starting new FIFO pops; an in-flight word always completes
fifo_empty  input  1  FIFO Empty flag
fifo_data  input  DATA_WIDTH  FIFO data_out; valid in the cycle after fifo_re is sampled
fifo_re  output  1  FIFO read strobe; exactly one cycle high per pop
byte_out  output  BYTE_WIDTH  current byte; 0 when byte_valid = 0
byte_valid  output  1  byte_out is valid
byte_ready  input  1  sink accepts the byte when byte_valid & byte_ready at a rising edge
byte_last  output  1  high with the final byte of each word
busy  output  1  high whenever state != IDLE
word_count  output  CNT_WIDTH  number of fully transmitted words; wraps modulo 2^CNT_WIDTH

Behaviour:
- N = DATA_WIDTH/BYTE_WIDTH (4 at the defaults). The byte index counter is clog2(N) bits wide.
- Reset (rst = 0 at an edge): state goes to IDLE. shift_reg, byte index, and word_count clear to 0. fifo_re, byte_valid, byte_last, busy, and byte_out are all 0 in the following cycle.
- Reset mid-operation discards the partially sent word. That word is not counted.
- The FSM is a Moore machine with four states: IDLE, POP, LOAD, SEND.
- IDLE: if en = 1 and fifo_empty = 0, go to POP. Otherwise stay in IDLE.
- POP: fifo_re = 1 for this single cycle. Always go to LOAD.
- LOAD: fifo_data is valid in this cycle. Capture it into shift_reg, set index to 0, and go to SEND.
- SEND: byte_valid = 1.
  - byte_out = shift_reg byte[index] when MSB_FIRST = 0, or byte[N-1-index] when MSB_FIRST = 1.
  - byte_last = (index == N-1).
  - On a handshake with index < N-1: index increments.
  - On a handshake with index == N-1: word_count increments. Then go to POP if en & !fifo_empty, else go to IDLE.
- Backpressure: while byte_valid = 1 and byte_ready = 0, byte_out and byte_last hold stable. byte_valid is never withdrawn before its handshake.
- Latency: from IDLE with data available, the first byte_valid appears 3 cycles after en & !fifo_empty is sampled (IDLE→POP→LOAD→SEND).
- Steady-state throughput: N bytes per N+2 cycles when byte_ready is held at 1.
- fifo_re is never asserted while fifo_empty = 1 at the deciding edge. The block never under-reads the FIFO.
- fifo_empty is only sampled in IDLE and at the final-byte handshake.
- en deasserted during POP, LOAD, or SEND: the current word finishes, then the FSM returns to IDLE.
- byte_ready is ignored outside SEND.
- word_count wraps from 2^CNT_WIDTH-1 to 0 without a flag.

Decomposition:
- Shared package fifo_pkg holds:
  - the state enum (IDLE, POP, LOAD, SEND)
  - the constants DATA_WIDTH = 32 and BYTE_WIDTH = 8
  - the derived constants BYTES_PER_WORD and IDX_WIDTH
- One sub-module, byte_select: a combinational N:1 byte mux with MSB_FIRST ordering.
- The FSM, shift register, and counters stay in the top module.

Test Plan:
1. Bench FIFO model with 1-cycle read latency; push 0x04030201; en = 1, byte_ready = 1 → fifo_re pulses once; bytes 0x01, 0x02, 0x03, 0x04 arrive on consecutive cycles; byte_last only on 0x04; word_count = 1; busy returns to 0.
2. MSB_FIRST = 1, push 0x04030201 → bytes 0x04, 0x03, 0x02, 0x01.
3. Backpressure: hold byte_ready = 0 for 3 cycles while byte 0x02 is presented → byte_out stays 0x02 and byte_valid stays 1; no byte is dropped or duplicated; word_count = 1 at the end.
4. Back-to-back: write words 0x0, 0x1, 0x2, 0x3, 0x4 (the writer stimulus pattern), then en = 1 → 20 bytes in order; exactly 5 fifo_re pulses; word_count = 5; fifo_re stays 0 once fifo_empty = 1.
5. Empty and en gating:
   - fifo_empty = 1 with en = 1 for 50 cycles → fifo_re = 0 and busy = 0 throughout.
   - Drop en after byte 2 of 0xAABBCCDD while another word is queued → the word completes (DD, CC, BB, AA); no further pop occurs.
6. Reset mid-SEND: assert rst = 0 after byte 1 → next cycle byte_valid = 0, state IDLE, word_count = 0. After release, the next queued word streams from byte 0.
